// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//   Bundles the fetch-side lookup, the execute-side resolve/train bus and the
//   statistics outputs of the branch predictor.
//   master : pipeline side (drives fetch_pc and the resolved-branch fields)
//   slave  : predictor side (drives prediction, mispredict/redirect, stats)
// -----------------------------------------------------------------------------
interface branch_predictor_if;
   // fetch lookup
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   // execute resolve / train
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   // statistics
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   modport master (
      output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target,
      input  pred_taken, pred_target, mispredict, redirect_pc,
             stat_branches, stat_mispredicts
   );

   modport slave (
      input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target,
      output pred_taken, pred_target, mispredict, redirect_pc,
             stat_branches, stat_mispredicts
   );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage direction/target predictor: per-entry 2-bit saturating counter
//   plus a tagged target buffer, direct-mapped on pc[IDX_W+1:2]. Lookup is
//   purely combinational; training happens on the clock edge from the outcome
//   execute resolves. Mispredict detection and the corrected PC are also
//   combinational so the pipeline can flush on the same edge.
//
//   Ports
//     clk    : clock, all state updates on rising edge
//     rst_n  : asynchronous active-low reset
//     bp     : branch_predictor_if.slave (lookup, resolve/train, statistics)
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter  int ENTRIES = 64,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_predictor_if.slave  bp
);
   localparam int TAG_W = 32 - IDX_W - 2;

   // flat read views of the per-entry state
   logic [1:0]       ctr_q      [ENTRIES];
   logic             valid_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q      [ENTRIES];
   logic [31:0]      target_q   [ENTRIES];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             hit;
   logic [1:0]       ctr_cur, ctr_nxt;
   logic [31:0]      n_br, n_mp;

   // PC bits [1:0] never participate in indexing or tagging
   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

   assign f_idx = bp.fetch_pc[IDX_W+1:2];
   assign f_tag = bp.fetch_pc[31:IDX_W+2];
   assign u_idx = bp.upd_pc[IDX_W+1:2];
   assign u_tag = bp.upd_pc[31:IDX_W+2];

   // ---------------------------------------------------------------- lookup
   // Reads current state only; an update on the same edge is not bypassed.
   assign hit            = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign bp.pred_taken  = hit && ctr_q[f_idx][1];
   assign bp.pred_target = bp.pred_taken ? target_q[f_idx] : 32'd0;

   // ------------------------------------------------------ counter training
   assign ctr_cur = ctr_q[u_idx];

   always_comb begin
      ctr_nxt = ctr_cur;
      if (bp.upd_taken) begin
         if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
      end
   end

   // ------------------------------------------------------- per-entry state
   for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
      logic             we;
      logic [1:0]       ctr_r;
      logic             valid_r;
      logic [TAG_W-1:0] tag_r;
      logic [31:0]      target_r;

      assign we = bp.upd_valid && (u_idx == IDX_W'(e));

      // Reset dominates, so an update presented while rst_n is low is lost.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ctr_r    <= 2'b01;
            valid_r  <= 1'b0;
            tag_r    <= '0;
            target_r <= '0;
         end else if (we) begin
            ctr_r <= ctr_nxt;
            // Taken branches own the target slot, evicting any alias;
            // not-taken ones leave it alone.
            if (bp.upd_taken) begin
               valid_r  <= 1'b1;
               tag_r    <= u_tag;
               target_r <= bp.upd_target;
            end
         end
      end

      assign ctr_q[e]    = ctr_r;
      assign valid_q[e]  = valid_r;
      assign tag_q[e]    = tag_r;
      assign target_q[e] = target_r;
   end

   // ------------------------------------------------- mispredict / redirect
   assign bp.mispredict = bp.upd_valid &&
                          ((bp.upd_taken != bp.upd_pred_taken) ||
                           (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

   assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : (bp.upd_pc + 32'd4);

   // ------------------------------------------------------------ statistics
   // Saturating at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_br <= '0;
         n_mp <= '0;
      end else if (bp.upd_valid) begin
         if (n_br != '1) n_br <= n_br + 32'd1;
         if (bp.mispredict && (n_mp != '1)) n_mp <= n_mp + 32'd1;
      end
   end

   assign bp.stat_branches    = n_br;
   assign bp.stat_mispredicts = n_mp;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed vector table walking the predictor through training, saturation,
//   aliasing, mispredict/redirect and the same-cycle hazard; a hand sequence
//   for asynchronous reset mid-stream; then randomized traffic checked against
//   a behavioural model that remembers, per slot, the last taken PC/target and
//   a clamped integer confidence.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
   localparam int ENTRIES = 64;
   localparam int IDX_BITS = 6;

   logic clk;
   logic rst_n;

   branch_predictor_if bp();

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------ behavioural model
   int          m_conf  [ENTRIES];  // 0..3, taken when >= 2
   bit          m_valid [ENTRIES];
   logic [31:0] m_pc    [ENTRIES];  // full PC of last taken branch in slot
   logic [31:0] m_tgt   [ENTRIES];
   longint      m_br, m_mp;

   function automatic int slot(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_conf[i] = 1; m_valid[i] = 0; m_pc[i] = 0; m_tgt[i] = 0;
      end
      m_br = 0; m_mp = 0;
   endtask

   task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
      int i;
      i  = slot(pc);
      t  = m_valid[i] && ((m_pc[i] >> (IDX_BITS + 2)) == (pc >> (IDX_BITS + 2))) && (m_conf[i] >= 2);
      tg = t ? m_tgt[i] : 32'd0;
   endtask

   task automatic m_train(input logic [31:0] pc, input logic taken, input logic [31:0] target);
      int i;
      i = slot(pc);
      if (taken) begin
         m_conf[i]  = (m_conf[i] < 3) ? m_conf[i] + 1 : 3;
         m_valid[i] = 1; m_pc[i] = pc; m_tgt[i] = target;
      end else begin
         m_conf[i] = (m_conf[i] > 0) ? m_conf[i] - 1 : 0;
      end
   endtask

   // ---------------------------------------------------------- vector table
   typedef struct {
      logic [31:0] fetch_pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utg;
      logic        upt;
      logic [31:0] uptg;
      logic        e_pt;
      logic [31:0] e_tg;
      logic        e_mp;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [31:0] f, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic upt,
                      input logic [31:0] uptg, input logic ept, input logic [31:0] etg,
                      input logic emp, input logic [31:0] erd);
      vec_t v;
      v.fetch_pc = f; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
      v.upt = upt; v.uptg = uptg; v.e_pt = ept; v.e_tg = etg; v.e_mp = emp; v.e_rd = erd;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [31:0] f, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic upt,
                        input logic [31:0] uptg);
      bp.fetch_pc = f; bp.upd_valid = uv; bp.upd_pc = upc; bp.upd_taken = ut;
      bp.upd_target = utg; bp.upd_pred_taken = upt; bp.upd_pred_target = uptg;
   endtask

   initial begin
      int exp_br, exp_mp;
      logic        rt, rpt, rut, ruv, mp_e;
      logic [31:0] rtg, rpc, rfpc, rutg, rptg, rd_e;

      drive(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // fetch  uv upc          ut utg    upt uptg    e_pt e_tg  e_mp e_rd
      add(32'h100,  0, 0,            0, 0,      0, 0,       0, 0,      0, 0);
      add(32'h100,  1, 32'h100,      1, 32'h80, 0, 0,       0, 0,      1, 32'h80);  // hazard: pre-update view
      add(32'h100,  1, 32'h100,      1, 32'h80, 1, 32'h80,  1, 32'h80, 0, 32'h80);  // ctr 10 visible
      add(32'h100,  1, 32'h100,      0, 32'h80, 1, 32'h80,  1, 32'h80, 1, 32'h104); // ctr 11 -> 10
      add(32'h100,  0, 0,            0, 0,      0, 0,       1, 32'h80, 0, 0);
      add(32'h1100, 0, 0,            0, 0,      0, 0,       0, 0,      0, 0);       // alias: tag miss
      add(32'h1100, 1, 32'h1100,     1, 32'h40, 0, 0,       0, 0,      1, 32'h40);  // steal slot, ctr 11
      add(32'h100,  0, 0,            0, 0,      0, 0,       0, 0,      0, 0);       // old owner misses
      add(32'h1100, 0, 0,            0, 0,      0, 0,       1, 32'h40, 0, 0);
      add(32'h1100, 1, 32'h200,      0, 0,      0, 0,       1, 32'h40, 0, 32'h204); // 11 -> 10
      add(32'h1100, 1, 32'h200,      0, 0,      0, 0,       1, 32'h40, 0, 32'h204); // 10 -> 01
      add(32'h1100, 1, 32'h200,      0, 0,      0, 0,       0, 0,      0, 32'h204); // 01 -> 00
      add(32'h1100, 1, 32'h200,      0, 0,      0, 0,       0, 0,      0, 32'h204); // stays 00
      add(32'h1100, 1, 32'h200,      0, 0,      0, 0,       0, 0,      0, 32'h204); // stays 00
      add(32'h1100, 1, 32'h200,      1, 32'h300,0, 0,       0, 0,      1, 32'h300); // 00 -> 01
      add(32'h200,  0, 0,            0, 0,      0, 0,       0, 0,      0, 0);       // hit, weak-NT
      add(32'h0,    1, 32'h300,      0, 0,      1, 32'h304, 0, 0,      1, 32'h304); // 01 -> 00
      add(32'h0,    1, 32'h300,      1, 32'h20, 1, 32'h10,  0, 0,      1, 32'h20);  // wrong target
      add(32'h300,  0, 0,            0, 0,      0, 0,       0, 0,      0, 0);
      add(32'h300,  1, 32'h300,      1, 32'h20, 1, 32'h20,  0, 0,      0, 32'h20);  // correct prediction
      add(32'h300,  0, 0,            0, 0,      0, 0,       1, 32'h20, 0, 0);
      add(32'h300,  1, 32'hFFFF_FFFC,0, 0,      0, 0,       1, 32'h20, 0, 32'h0);   // +4 wraps

      exp_br = 0; exp_mp = 0;
      foreach (vq[k]) begin
         drive(vq[k].fetch_pc, vq[k].uv, vq[k].upc, vq[k].ut, vq[k].utg, vq[k].upt, vq[k].uptg);
         #1;
         chk($sformatf("vec%0d.pred_taken", k),  32'(bp.pred_taken),  32'(vq[k].e_pt));
         chk($sformatf("vec%0d.pred_target", k), bp.pred_target,      vq[k].e_tg);
         chk($sformatf("vec%0d.mispredict", k),  32'(bp.mispredict),  32'(vq[k].e_mp));
         if (vq[k].uv) chk($sformatf("vec%0d.redirect_pc", k), bp.redirect_pc, vq[k].e_rd);
         chk($sformatf("vec%0d.stat_branches", k),    bp.stat_branches,    32'(exp_br));
         chk($sformatf("vec%0d.stat_mispredicts", k), bp.stat_mispredicts, 32'(exp_mp));
         if (vq[k].uv) exp_br++;
         if (vq[k].e_mp) exp_mp++;
         @(posedge clk); #1;
      end
      chk("table.stat_branches_final", bp.stat_branches, 32'd14);
      chk("table.stat_mispredicts_final", bp.stat_mispredicts, 32'd6);

      // ---- asynchronous reset mid-stream, with an update on the reset edge
      drive(32'h300, 0, 0, 0, 0, 0, 0);
      #1 chk("pre_reset.pred_taken", 32'(bp.pred_taken), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset.pred_taken", 32'(bp.pred_taken), 32'd0);
      chk("async_reset.pred_target", bp.pred_target, 32'd0);
      chk("async_reset.stat_branches", bp.stat_branches, 32'd0);
      chk("async_reset.stat_mispredicts", bp.stat_mispredicts, 32'd0);
      drive(32'h300, 1, 32'h300, 1, 32'h20, 0, 0);
      #1 chk("reset.mispredict_follows_valid", 32'(bp.mispredict), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(32'h300, 0, 0, 0, 0, 0, 0);
      #1;
      chk("reset_edge_update_dropped.pred_taken", 32'(bp.pred_taken), 32'd0);
      chk("reset_edge_update_dropped.stat_branches", bp.stat_branches, 32'd0);
      chk("idle.mispredict", 32'(bp.mispredict), 32'd0);
      @(posedge clk); #1;

      // ---- randomized traffic against the model
      m_reset();
      for (int c = 0; c < 600; c++) begin
         rfpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         rpc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         if (($urandom % 16) == 0) rpc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         ruv  = ($urandom % 4) != 0;
         rut  = $urandom_range(0, 1) == 1;
         rutg = ($urandom % 2) ? 32'($urandom) : ((32'($urandom_range(0, 3))) << 4);
         if ($urandom % 2) begin
            m_lookup(rpc, rpt, rptg);
         end else begin
            rpt  = $urandom_range(0, 1) == 1;
            rptg = ($urandom % 2) ? rutg : 32'($urandom);
         end
         drive(rfpc, ruv, rpc, rut, rutg, rpt, rptg);
         #1;
         m_lookup(rfpc, rt, rtg);
         mp_e = ruv && ((rut != rpt) || (rut && (rutg != rptg)));
         rd_e = rut ? rutg : rpc + 32'd4;
         chk("rand.pred_taken",  32'(bp.pred_taken), 32'(rt));
         chk("rand.pred_target", bp.pred_target, rtg);
         chk("rand.mispredict",  32'(bp.mispredict), 32'(mp_e));
         if (ruv) chk("rand.redirect_pc", bp.redirect_pc, rd_e);
         chk("rand.stat_branches",    bp.stat_branches,    32'(m_br));
         chk("rand.stat_mispredicts", bp.stat_mispredicts, 32'(m_mp));
         @(posedge clk); #1;
         if (ruv) begin
            m_train(rpc, rut, rutg);
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (mp_e && m_mp < 64'hFFFF_FFFF) m_mp++;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor paired with the execute-stage branch condition generator. Predicts the direction and target of conditional branches at fetch using a table of 2-bit saturating counters and a tagged target buffer. Trains from the resolved outcome that execute reports back. Flags mispredictions and supplies the corrected PC to the pipeline's PC mux.

## Interface
- `ENTRIES`, 64: number of counter and target entries; power of two, 4..1024.
- `IDX_W`, $clog2(ENTRIES): index width; derived, not overridden.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `fetch_pc` input 32: PC of the instruction being fetched.
- `pred_taken` output 1: predicted taken for `fetch_pc`.
- `pred_target` output 32: predicted target; 0 when `pred_taken`=0.
- `upd_valid` input 1: execute holds a resolved conditional branch this cycle.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_taken` input 1: resolved outcome from the branch condition generator.
- `upd_target` input 32: computed branch target (PC + B-immediate).
- `upd_pred_taken` input 1: prediction made for this branch at fetch, piped down.
- `upd_pred_target` input 32: target predicted at fetch, piped down.
- `mispredict` output 1: prediction for the resolving branch was wrong.
- `redirect_pc` output 32: correct next PC; valid when `mispredict`=1.
- `stat_branches` output 32: count of resolved branches.
- `stat_mispredicts` output 32: count of mispredictions.

## Operation
- Index: `idx = pc[IDX_W+1:2]`; tag: `pc[31:IDX_W+2]`. PC bits [1:0] are ignored.
- State per entry: `ctr` (2 bits), `btb_valid` (1 bit), `btb_tag`, `btb_target` (32 bits).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from current state:
  - `hit = btb_valid[idx] && btb_tag[idx]==tag`.
  - `pred_taken = hit && ctr[idx][1]`.
  - `pred_target = pred_taken ? btb_target[idx] : 0`.
- Update happens on a clock edge with `upd_valid`=1, indexed by `upd_pc`:
  - `ctr` increments if `upd_taken`, otherwise decrements.
  - `ctr` saturates at 11 and 00; it never wraps.
  - If `upd_taken`, the target entry is written: valid=1, tag=`upd_pc` tag, target=`upd_target`. This overwrites any aliasing entry.
  - Not-taken updates leave the target entry unchanged.
- Mispredict detection is combinational, gated by `upd_valid`:
  - `mispredict = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)`.
- `redirect_pc = upd_taken ? upd_target : upd_pc + 4`, with 32-bit wrap.
- Statistics, on an edge with `upd_valid`=1:
  - `stat_branches` increments.
  - `stat_mispredicts` increments when `mispredict`=1.
  - Both saturate at 32'hFFFF_FFFF.
- `upd_valid`=0: no state changes; `mispredict`=0.

## Timing
- Reset (async assert, sync-to-`clk` release):
  - All `ctr` = 01 (weak-NT).
  - All `btb_valid` = 0.
  - `btb_tag` and `btb_target` = 0.
  - Both stat counters = 0.
- Effect of reset on outputs:
  - `pred_taken`=0 and `pred_target`=0 immediately on assert.
  - `mispredict` follows `upd_valid`.
- Lookup latency is 0 cycles: combinational from `fetch_pc`.
- An update becomes visible to lookup the cycle after the edge that captures it.
- Same-cycle lookup and update of the same index: lookup sees the pre-update state. There is no bypass.
- `mispredict` and `redirect_pc` are valid in the same cycle as `upd_valid`. The pipeline flushes on that cycle's edge.
- Reset asserted mid-training:
  - All learned state is lost.
  - An update presented on the edge coinciding with reset is discarded.
- Back-to-back updates to the same index on consecutive cycles each apply in order. Two taken updates move 01 → 10 → 11.

## Test plan
- Reset values:
  - Stimulus: release reset, lookup `fetch_pc`=0x100.
  - Required: `pred_taken`=0, `pred_target`=0, both stats = 0.
- Training to taken:
  - Stimulus: two taken updates at `upd_pc`=0x100 with `upd_target`=0x80, then lookup 0x100.
  - Required: after the 1st update `pred_taken`=1, `pred_target`=0x80 (ctr=10). After the 2nd update ctr=11; one not-taken update keeps `pred_taken`=1.
- Saturation:
  - Stimulus: five not-taken updates at 0x200.
  - Required: ctr stays 00 with no wrap. Then one taken update yields ctr=01, so `pred_taken`=0.
- Aliasing and tag:
  - Stimulus: train 0x100 taken (ENTRIES=64), then lookup 0x1100.
  - Required: same index but different tag, so `pred_taken`=0.
  - Stimulus: taken update at 0x1100 with target 0x40.
  - Required: 0x100 now misses its tag.
- Mispredict and redirect:
  - Stimulus: `upd_pc`=0x300, `upd_taken`=0, `upd_pred_taken`=1.
  - Required: `mispredict`=1, `redirect_pc`=0x304.
  - Stimulus: `upd_taken`=1, `upd_pred_taken`=1, `upd_pred_target`=0x10, `upd_target`=0x20.
  - Required: `mispredict`=1, `redirect_pc`=0x20, `stat_mispredicts` +1.
- Same-cycle hazard and reset:
  - Stimulus: lookup 0x100 while a taken update at 0x100 is applied from weak-NT.
  - Required: that cycle `pred_taken`=0, next cycle `pred_taken`=1.
  - Stimulus: assert `rst_n`=0 mid-stream.
  - Required: all predictions and stats return to reset values asynchronously.
